ascii_hex_parser: RTL and testbench

- Inverse of the team's binary-to-ASCII-hex converter: consumes a byte stream of ASCII hex characters (e.g. from the UART RX path) and assembles them into an NBYTES*8-bit binary word.
- Sits between the serial receiver and any register/command logic that takes typed hex values.
- Valid/ready handshake on both sides; explicit error flag for non-hex characters.

---
 rtl/ascii_hex_parser.sv | 177 +++++++++++++++++
 tb/tb_ascii_hex_parser.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/ascii_hex_parser.sv
// ascii_hex_parser
// Assembles a stream of ASCII hex characters into an NBYTES*8-bit binary word.
// The last digit received lands in out_data[3:0]. A word is emitted when
// NBYTES*2 digits have arrived, or earlier on a delimiter (CR, LF, space), in
// which case it is right-justified and zero-extended. An illegal character
// pulses err once and drops input until the next delimiter.

module ascii_hex_parser #(
    parameter int NBYTES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [NBYTES*8-1:0]   out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  err
);

    localparam int W    = NBYTES * 8;
    localparam int NDIG = NBYTES * 2;
    localparam int CW   = $clog2(NDIG + 1);

    localparam logic [CW-1:0] FULL_COUNT = CW'(NDIG);
    localparam logic [CW-1:0] ONE        = CW'(1);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        DISCARD = 2'd1,
        OUTPUT  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        CH_DIGIT   = 2'd0,
        CH_DELIM   = 2'd1,
        CH_ILLEGAL = 2'd2
    } char_class_t;

    // Sort an incoming character into digit / delimiter / illegal.
    function automatic char_class_t classify(input logic [7:0] c);
        if ((c >= 8'h30 && c <= 8'h39) ||
            (c >= 8'h41 && c <= 8'h46) ||
            (c >= 8'h61 && c <= 8'h66)) begin
            return CH_DIGIT;
        end else if (c == 8'h0D || c == 8'h0A || c == 8'h20) begin
            return CH_DELIM;
        end else begin
            return CH_ILLEGAL;
        end
    endfunction

    // Nibble value of a hex digit. For letters the low four bits run 1..6 in
    // both cases, so adding 9 yields A..F without a case split.
    function automatic logic [3:0] nibble_of(input logic [7:0] c);
        if (c <= 8'h39) begin
            return c[3:0];
        end else begin
            return c[3:0] + 4'd9;
        end
    endfunction

    state_t          state, state_d;
    logic [W-1:0]    acc, acc_d;
    logic [CW-1:0]   count, count_d;
    logic [W-1:0]    out_data_d;
    logic            out_valid_d;
    logic            err_d;

    char_class_t     cls;
    logic [3:0]      nibble;
    logic [W-1:0]    acc_shift;
    logic [CW-1:0]   count_inc;
    logic            accept;

    assign cls       = classify(in_data);
    assign nibble    = nibble_of(in_data);
    assign acc_shift = {acc[W-5:0], nibble};
    assign count_inc = count + ONE;
    assign accept    = in_valid && in_ready;

    // State and datapath registers with synchronous reset.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= COLLECT;
            acc       <= '0;
            count     <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_d;
            acc       <= acc_d;
            count     <= count_d;
            out_data  <= out_data_d;
            out_valid <= out_valid_d;
            err       <= err_d;
        end
    end

    // Next-state and next-datapath decision for each accepted character.
    // NOTE: every target gets a hold/default value first so no path through
    // the case statement leaves one unassigned, which would infer a latch.
    always_comb begin
        state_d     = state;
        acc_d       = acc;
        count_d     = count;
        out_data_d  = out_data;
        out_valid_d = out_valid;
        err_d       = 1'b0;

        case (state)
            COLLECT: begin
                if (accept) begin
                    case (cls)
                        CH_DIGIT: begin
                            if (count_inc == FULL_COUNT) begin
                                out_data_d  = acc_shift;
                                out_valid_d = 1'b1;
                                acc_d       = '0;
                                count_d     = '0;
                                state_d     = OUTPUT;
                            end else begin
                                acc_d   = acc_shift;
                                count_d = count_inc;
                            end
                        end
                        CH_DELIM: begin
                            // A delimiter with no pending digits is ignored.
                            if (count != '0) begin
                                out_data_d  = acc;
                                out_valid_d = 1'b1;
                                acc_d       = '0;
                                count_d     = '0;
                                state_d     = OUTPUT;
                            end
                        end
                        default: begin
                            err_d   = 1'b1;
                            acc_d   = '0;
                            count_d = '0;
                            state_d = DISCARD;
                        end
                    endcase
                end
            end

            DISCARD: begin
                // acc and count were cleared on entry; only a delimiter
                // ends the discard run, and it produces no word.
                if (accept && cls == CH_DELIM) begin
                    state_d = COLLECT;
                end
            end

            OUTPUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = COLLECT;
                end
            end

            default: begin
                state_d = COLLECT;
            end
        endcase
    end

    // Input backpressure: closed while a word waits for its consumer.
    always_comb begin
        in_ready = !rst && (state != OUTPUT);
    end

endmodule

// File: tb/tb_ascii_hex_parser.sv
// tb_ascii_hex_parser
// Self-checking bench: expected words are queued as stimulus is driven and
// compared as the parser hands them out.

module tb_ascii_hex_parser;

    localparam int NBYTES = 2;
    localparam int W      = NBYTES * 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [7:0]     in_data;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   out_data;
    logic           out_valid;
    logic           out_ready;
    logic           err;

    int n_checks   = 0;
    int n_pass     = 0;
    int err_pulses = 0;

    logic [W-1:0] sb[$];

    ascii_hex_parser #(.NBYTES(NBYTES)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Output monitor: score every completed handshake, count err pulses.
    always @(negedge clk) begin
        if (err) err_pulses++;
        if (out_valid && out_ready) begin
            check("sb_has_entry", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) check("word", 32'(out_data), 32'(sb.pop_front()));
        end
    end

    // Present one character and hold it until accepted. Called and returns
    // 1 time unit after a rising edge.
    task automatic send(input logic [7:0] c);
        logic taken;
        taken    = 1'b0;
        in_data  = c;
        in_valid = 1'b1;
        for (int i = 0; i < 50 && !taken; i++) begin
            @(negedge clk);
            taken = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check("send_accepted", 32'(taken), 32'd1);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        in_data   = 8'h00;
        in_valid  = 1'b0;
        out_ready = 1'b1;

        // Reset state
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_in_ready",  32'(in_ready),  32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_err",       32'(err),       32'd0);
        check("rst_out_data",  32'(out_data),  32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("in_ready_after_rst", 32'(in_ready), 32'd1);
        @(posedge clk); #1;

        // Full word, mixed case: "12aF"
        sb.push_back(16'h12AF);
        send(8'h31); send(8'h32); send(8'h61); send(8'h46);
        @(negedge clk);
        check("t1_valid_pulse", 32'(out_valid), 32'd1);
        @(negedge clk);
        check("t1_valid_drop", 32'(out_valid), 32'd0);
        check("t1_no_err", 32'(err_pulses), 32'd0);
        @(posedge clk); #1;

        // Short word on delimiter, then lone delimiters
        sb.push_back(16'h0007);
        send(8'h37); send(8'h0D);
        send(8'h0D); send(8'h0A); send(8'h20);
        idle(4);
        check("t2_sb_drained", sb.size(), 0);
        check("t2_no_err", 32'(err_pulses), 32'd0);

        // Backpressure: word held while out_ready is low
        out_ready = 1'b0;
        sb.push_back(16'h1234);
        send(8'h31); send(8'h32); send(8'h33); send(8'h34);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t3_held_valid", 32'(out_valid), 32'd1);
            check("t3_held_data",  32'(out_data),  32'h1234);
            check("t3_in_ready",   32'(in_ready),  32'd0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        check("t3_in_ready_back", 32'(in_ready), 32'd1);
        check("t3_sb_drained", sb.size(), 0);
        @(posedge clk); #1;

        // Illegal characters: err on 'G' only, then recovery
        sb.push_back(16'h0005);
        send(8'h31); send(8'h47);
        @(negedge clk);
        check("t4_err_on_G", 32'(err), 32'd1);
        @(posedge clk); #1;
        send(8'h39); send(8'h78);
        @(negedge clk);
        check("t4_no_err_on_x", 32'(err), 32'd0);
        @(posedge clk); #1;
        send(8'h0D); send(8'h35); send(8'h0D);
        idle(4);
        check("t4_err_count", 32'(err_pulses), 32'd1);
        check("t4_sb_drained", sb.size(), 0);

        // Overflow rolls into a new word: "ABCDE\r"
        sb.push_back(16'hABCD);
        sb.push_back(16'h000E);
        send(8'h41); send(8'h42); send(8'h43); send(8'h44);
        send(8'h45); send(8'h0D);
        idle(4);
        check("t5_sb_drained", sb.size(), 0);

        // Reset mid-word discards partial digits
        sb.push_back(16'h0003);
        send(8'h31); send(8'h32);
        rst = 1'b1;
        @(negedge clk);
        check("t6_rst_in_ready",  32'(in_ready),  32'd0);
        check("t6_rst_out_valid", 32'(out_valid), 32'd0);
        check("t6_rst_err",       32'(err),       32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("t6_post_out_valid", 32'(out_valid), 32'd0);
        check("t6_post_err",       32'(err),       32'd0);
        check("t6_post_in_ready",  32'(in_ready),  32'd1);
        @(posedge clk); #1;
        send(8'h33); send(8'h0D);
        idle(4);
        check("t6_sb_drained", sb.size(), 0);
        check("final_err_count", 32'(err_pulses), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
